// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes and the frame-sequencer state encoding.
// Used by the configurable transmitter and the matching receiver.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  // Parity bit for a data word under the given mode; 0 when parity is disabled.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    logic p;
    p = ^data;
    case (mode)
      PARITY_ODD:  parity_bit = ~p;
      PARITY_EVEN: parity_bit = p;
      default:     parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLK_PER_BIT-1 while enabled and flags the last cycle.
// clear restarts the period so a new frame starts on a full bit boundary.
module uart_baud_cnt #(
  parameter int CLK_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (data width, parity, stop bits) with a valid/ready input.
// txd and busy are registered; tx_ready is decoded straight from the state register.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);

  if (CLK_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_cfg: CLK_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam bit HAS_PARITY = (PARITY != PARITY_NONE);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 parity_q, parity_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 accept;
  logic                 tick;

  assign tx_ready = (state_q == S_IDLE);
  assign accept   = tx_ready && tx_valid;

  uart_baud_cnt #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .enable(state_q != S_IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    txd_d    = txd_q;
    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (accept) begin
          state_d  = S_START;
          shift_d  = tx_data;
          parity_d = parity_bit(9'(tx_data), PARITY);
          idx_d    = '0;
          txd_d    = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
            if (HAS_PARITY) begin
              state_d = S_PARITY;
              txd_d   = parity_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            // Shift toward bit 0 so the next data bit is always shift_q[1].
            idx_d   = idx_q + IW'(1);
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            txd_d   = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (tick) begin
          if (idx_q == LAST_STOP) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule
